// File: rtl/ssd_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ssd_pkg
//  Description : Shared seven-segment types and the hex glyph table used by
//                the scan driver and its decoder.
//  Revision    : 1.0 - initial release
// ============================================================================
package ssd_pkg;

    localparam int SEG_W = 7;

    // Segment vector, bit order gfedcba (bit 6 = g)
    typedef logic [SEG_W-1:0] seg_t;

    // All segments off in active-low terms
    localparam seg_t SEG_BLANK = 7'b1111111;

    // Active-low glyphs for 0..F; polarity flipping happens in the driver
    localparam seg_t SEG_TABLE [16] = '{
        7'b1000000,  // 0
        7'b1111001,  // 1
        7'b0100100,  // 2
        7'b0110000,  // 3
        7'b0011001,  // 4
        7'b0010010,  // 5
        7'b0000010,  // 6
        7'b1111000,  // 7
        7'b0000000,  // 8
        7'b0010000,  // 9
        7'b0001000,  // A
        7'b0000011,  // b
        7'b1000110,  // C
        7'b0100001,  // d
        7'b0000110,  // E
        7'b0001110   // F
    };

endpackage
`default_nettype wire

// File: rtl/ssd_hex_decode.sv
`default_nettype none
// ============================================================================
//  Module      : ssd_hex_decode
//  Description : Combinational digit value to active-low segment pattern.
//                Narrow (3-bit) values are zero-extended into the table.
//  Revision    : 1.0 - initial release
// ============================================================================
module ssd_hex_decode
    import ssd_pkg::*;
#(
    parameter int VAL_W = 4
) (
    input  logic [VAL_W-1:0] i_value,
    output seg_t             o_seg
);

    logic [3:0] w_index;

    // Table lookup on the zero-extended digit value
    always_comb begin
        w_index = 4'(i_value);
        o_seg   = SEG_TABLE[w_index];
    end

endmodule
`default_nettype wire

// File: rtl/ssd_scan_driver.sv
`default_nettype none
// ============================================================================
//  Module      : ssd_scan_driver
//  Description : Time-multiplexed driver for NUM_DIGITS seven-segment digits
//                on a shared segment bus. Values are loaded into a shadow
//                buffer through a ready/valid handshake and promoted to the
//                displayed (active) buffer only at a frame boundary, so a
//                frame never mixes old and new digits.
//                Optional macro SSD_SCAN_DRIVER_BLINK_EN adds a per-digit
//                blink mask and a BLINK_FRAMES blink period.
//  Revision    : 1.0 - initial release
// ============================================================================
module ssd_scan_driver
    import ssd_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int VAL_W        = 4,
    parameter int SCAN_DIV     = 100000,
    parameter bit ACTIVE_LOW   = 1'b1
`ifdef SSD_SCAN_DRIVER_BLINK_EN
    ,
    parameter int BLINK_FRAMES = 64
`endif
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        load_valid,
    output logic                        load_ready,
    input  logic [NUM_DIGITS*VAL_W-1:0] values,
    input  logic [NUM_DIGITS-1:0]       digit_en,
`ifdef SSD_SCAN_DRIVER_BLINK_EN
    input  logic [NUM_DIGITS-1:0]       blink_mask,
`endif
    output seg_t                        seg,
    output logic [NUM_DIGITS-1:0]       an,
    output logic                        frame_done
);

    localparam int c_presc_w = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int c_idx_w   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [c_presc_w-1:0]  c_presc_max = c_presc_w'(SCAN_DIV - 1);
    localparam logic [c_idx_w-1:0]    c_idx_max   = c_idx_w'(NUM_DIGITS - 1);
    localparam seg_t                  c_seg_off   = ACTIVE_LOW ? SEG_BLANK : ~SEG_BLANK;
    localparam logic [NUM_DIGITS-1:0] c_an_off    = ACTIVE_LOW ? '1 : '0;

    // Scan timing
    logic [c_presc_w-1:0] r_presc;
    logic [c_idx_w-1:0]   r_idx;
    logic                 w_tick;
    logic                 w_frame_done;

    // Double buffer and handshake
    logic [NUM_DIGITS*VAL_W-1:0] r_act_vals;
    logic [NUM_DIGITS*VAL_W-1:0] r_shd_vals;
    logic [NUM_DIGITS-1:0]       r_act_en;
    logic [NUM_DIGITS-1:0]       r_shd_en;
    logic                        r_pending;
    logic                        w_load;
    logic                        w_swap;

    // Output path
    logic [VAL_W-1:0]      w_sel_val;
    seg_t                  w_dec_seg;
    seg_t                  w_seg_low;
    logic                  w_show;
    logic [NUM_DIGITS-1:0] w_onehot;
    seg_t                  r_seg;
    logic [NUM_DIGITS-1:0] r_an;

    assign w_tick       = (r_presc == c_presc_max);
    assign w_frame_done = w_tick && (r_idx == c_idx_max);
    assign w_load       = load_valid && !r_pending;
    assign w_swap       = w_frame_done && r_pending;

    assign load_ready = !r_pending;
    assign frame_done = w_frame_done;
    assign seg        = r_seg;
    assign an         = r_an;

    // Prescaler wraps every SCAN_DIV cycles; digit index steps on each wrap
    always_ff @(posedge clk) begin
        if (rst) begin
            r_presc <= '0;
            r_idx   <= '0;
        end else begin
            if (w_tick) begin
                r_presc <= '0;
                r_idx   <= (r_idx == c_idx_max) ? '0 : r_idx + 1'b1;
            end else begin
                r_presc <= r_presc + 1'b1;
            end
        end
    end

    // Shadow capture on accepted load; promotion to active only at frame end.
    // A load and a swap never coincide: load needs !pending, swap needs pending.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_act_vals <= '0;
            r_shd_vals <= '0;
            r_act_en   <= '0;
            r_shd_en   <= '0;
            r_pending  <= 1'b0;
        end else begin
            if (w_load) begin
                r_shd_vals <= values;
                r_shd_en   <= digit_en;
            end
            if (w_swap) begin
                r_act_vals <= r_shd_vals;
                r_act_en   <= r_shd_en;
            end
            if (w_swap) begin
                r_pending <= 1'b0;
            end else if (w_load) begin
                r_pending <= 1'b1;
            end
        end
    end

`ifdef SSD_SCAN_DRIVER_BLINK_EN
    localparam int c_blink_w = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [c_blink_w-1:0] c_blink_max = c_blink_w'(BLINK_FRAMES - 1);

    logic [NUM_DIGITS-1:0] r_shd_blink;
    logic [NUM_DIGITS-1:0] r_act_blink;
    logic [c_blink_w-1:0]  r_blink_cnt;
    logic                  r_blink_phase;

    // Blink mask follows the same shadow/active path as the digit values
    always_ff @(posedge clk) begin
        if (rst) begin
            r_shd_blink <= '0;
            r_act_blink <= '0;
        end else begin
            if (w_load) begin
                r_shd_blink <= blink_mask;
            end
            if (w_swap) begin
                r_act_blink <= r_shd_blink;
            end
        end
    end

    // Blink phase flips after every BLINK_FRAMES completed frames
    always_ff @(posedge clk) begin
        if (rst) begin
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b0;
        end else if (w_frame_done) begin
            if (r_blink_cnt == c_blink_max) begin
                r_blink_cnt   <= '0;
                r_blink_phase <= ~r_blink_phase;
            end else begin
                r_blink_cnt <= r_blink_cnt + 1'b1;
            end
        end
    end

    assign w_show = r_act_en[r_idx] && !(r_blink_phase && r_act_blink[r_idx]);
`else
    assign w_show = r_act_en[r_idx];
`endif

    assign w_sel_val = r_act_vals[r_idx*VAL_W +: VAL_W];

    ssd_hex_decode #(
        .VAL_W   (VAL_W)
    ) u_decode (
        .i_value (w_sel_val),
        .o_seg   (w_dec_seg)
    );

    // Select glyph or blank for the current slot and build the anode one-hot
    always_comb begin
        w_seg_low = SEG_BLANK;
        if (w_show) begin
            w_seg_low = w_dec_seg;
        end
        w_onehot = NUM_DIGITS'(1) << r_idx;
    end

    // Register seg and an together so the anode never leads the segments
    always_ff @(posedge clk) begin
        if (rst) begin
            r_seg <= c_seg_off;
            r_an  <= c_an_off;
        end else begin
            r_seg <= ACTIVE_LOW ? w_seg_low : ~w_seg_low;
            r_an  <= ACTIVE_LOW ? ~w_onehot : w_onehot;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ssd_scan_driver.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_ssd_scan_driver
//  Description : Self-checking bench for ssd_scan_driver (4 digits, 4-bit
//                values, SCAN_DIV=4, active-low). Expected digit slots are
//                queued when a value set is driven and popped per slot.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ssd_scan_driver;

    localparam int ND = 4;
    localparam int VW = 4;
    localparam int SD = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        load_valid;
    logic        load_ready;
    logic [15:0] values;
    logic [3:0]  digit_en;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        frame_done;
`ifdef SSD_SCAN_DRIVER_BLINK_EN
    logic [3:0]  blink_mask;
`endif

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
    } slot_t;

    slot_t sb[$];

    // Reference glyphs, active-low, gfedcba
    logic [6:0] hex_lut [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    ssd_scan_driver #(
        .NUM_DIGITS   (ND),
        .VAL_W        (VW),
        .SCAN_DIV     (SD),
        .ACTIVE_LOW   (1'b1)
`ifdef SSD_SCAN_DRIVER_BLINK_EN
        ,
        .BLINK_FRAMES (2)
`endif
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .values     (values),
        .digit_en   (digit_en),
`ifdef SSD_SCAN_DRIVER_BLINK_EN
        .blink_mask (blink_mask),
`endif
        .seg        (seg),
        .an         (an),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    // Expected output of one digit slot
    function automatic slot_t exp_slot(input logic [15:0] v, input logic [3:0] en,
                                       input logic [3:0] blank, input int d);
        slot_t      s;
        logic [3:0] nib;
        logic [3:0] one;
        one   = 4'b0001;
        nib   = v[d*4 +: 4];
        s.an  = ~(one << d);
        s.seg = (en[d] && !blank[d]) ? hex_lut[nib] : 7'b1111111;
        return s;
    endfunction

    task automatic push_frame(input logic [15:0] v, input logic [3:0] en, input logic [3:0] blank);
        for (int d = 0; d < ND; d++) begin
            sb.push_back(exp_slot(v, en, blank, d));
        end
    endtask

    // Called at a negedge; offers one load for one cycle, reports ready as sampled
    task automatic drive_load(input logic [15:0] v, input logic [3:0] en, output logic rdy);
        values     = v;
        digit_en   = en;
        load_valid = 1'b1;
        rdy        = load_ready;
        @(negedge clk);
        load_valid = 1'b0;
    endtask

    // Bounded wait until frame_done is seen at a negedge
    task automatic wait_fd(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (frame_done === 1'b1) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    task automatic test_reset;
        slot_t exp;
        logic  rdy;
        bit    ok;
        int    cnt;
        rst        = 1'b1;
        load_valid = 1'b0;
        values     = '0;
        digit_en   = '0;
        repeat (3) @(negedge clk);
        checks++;
        if (seg !== 7'b1111111 || an !== 4'b1111 || load_ready !== 1'b1 || frame_done !== 1'b0) begin
            failures++;
            $display("FAIL reset_state seg=%b an=%b ready=%b fd=%b expected 1111111 1111 1 0",
                     seg, an, load_ready, frame_done);
        end
        rst = 1'b0;
        cnt = 0;
        while (frame_done !== 1'b1 && cnt < 100) begin
            @(negedge clk);
            cnt++;
        end
        checks++;
        if (cnt != 15) begin
            failures++;
            $display("FAIL first_frame_done cycles=%0d expected 15", cnt);
        end
        repeat (3) @(negedge clk);
        drive_load(16'h1234, 4'hF, rdy);
        checks++;
        if (rdy !== 1'b1) begin
            failures++;
            $display("FAIL load_before_reset ready=%b expected 1", rdy);
        end
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (seg !== 7'b1111111 || an !== 4'b1111 || load_ready !== 1'b1 || frame_done !== 1'b0) begin
                failures++;
                $display("FAIL midscan_reset cyc=%0d seg=%b an=%b ready=%b fd=%b expected 1111111 1111 1 0",
                         i, seg, an, load_ready, frame_done);
            end
        end
        rst = 1'b0;
        // Discarded shadow: first frame after reset must be all blank
        push_frame(16'h0000, 4'h0, 4'h0);
        wait_fd(ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL reset_fd_timeout seen=0 expected 1");
        end
        @(negedge clk);
        while (sb.size() > 0) begin
            exp = sb.pop_front();
            for (int c = 0; c < SD; c++) begin
                @(negedge clk);
                checks++;
                if (an !== exp.an || seg !== exp.seg) begin
                    failures++;
                    $display("FAIL reset_blank_frame an=%b seg=%b expected an=%b seg=%b",
                             an, seg, exp.an, exp.seg);
                end
            end
        end
    endtask

    task automatic test_scan;
        slot_t exp;
        logic  rdy;
        bit    ok;
        push_frame(16'h6521, 4'hF, 4'h0);
        drive_load(16'h6521, 4'hF, rdy);
        checks++;
        if (rdy !== 1'b1) begin
            failures++;
            $display("FAIL scan_load_accept ready=%b expected 1", rdy);
        end
        wait_fd(ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL scan_fd_timeout seen=0 expected 1");
        end
        @(negedge clk);
        while (sb.size() > 0) begin
            exp = sb.pop_front();
            for (int c = 0; c < SD; c++) begin
                @(negedge clk);
                checks++;
                if (an !== exp.an || seg !== exp.seg) begin
                    failures++;
                    $display("FAIL scan_slot an=%b seg=%b expected an=%b seg=%b",
                             an, seg, exp.an, exp.seg);
                end
            end
        end
    endtask

    task automatic test_back_to_back;
        slot_t exp;
        logic  rdy;
        bit    ok;
        push_frame(16'hA9B4, 4'hF, 4'h0);
        drive_load(16'hA9B4, 4'hF, rdy);
        checks++;
        if (rdy !== 1'b1) begin
            failures++;
            $display("FAIL b2b_first_accept ready=%b expected 1", rdy);
        end
        drive_load(16'h9876, 4'hF, rdy);
        checks++;
        if (rdy !== 1'b0) begin
            failures++;
            $display("FAIL b2b_second_reject ready=%b expected 0", rdy);
        end
        wait_fd(ok);
        checks++;
        if (!ok || load_ready !== 1'b0) begin
            failures++;
            $display("FAIL b2b_ready_at_fd seen_fd=%0d ready=%b expected 1 0", ok, load_ready);
        end
        @(negedge clk);
        checks++;
        if (load_ready !== 1'b1) begin
            failures++;
            $display("FAIL b2b_ready_after_fd ready=%b expected 1", load_ready);
        end
        while (sb.size() > 0) begin
            exp = sb.pop_front();
            for (int c = 0; c < SD; c++) begin
                @(negedge clk);
                checks++;
                if (an !== exp.an || seg !== exp.seg) begin
                    failures++;
                    $display("FAIL b2b_slot an=%b seg=%b expected an=%b seg=%b",
                             an, seg, exp.an, exp.seg);
                end
            end
        end
    endtask

    task automatic test_load_on_frame_done;
        slot_t exp;
        logic  rdy;
        bit    ok;
        // Frame now starting keeps the old set; the new set follows one frame later
        push_frame(16'hA9B4, 4'hF, 4'h0);
        push_frame(16'hFEDC, 4'hF, 4'h0);
        wait_fd(ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL fdload_fd_timeout seen=0 expected 1");
        end
        drive_load(16'hFEDC, 4'hF, rdy);
        checks++;
        if (rdy !== 1'b1 || load_ready !== 1'b0) begin
            failures++;
            $display("FAIL fdload_capture ready_at_fd=%b ready_after=%b expected 1 0", rdy, load_ready);
        end
        while (sb.size() > 0) begin
            exp = sb.pop_front();
            for (int c = 0; c < SD; c++) begin
                @(negedge clk);
                checks++;
                if (an !== exp.an || seg !== exp.seg) begin
                    failures++;
                    $display("FAIL fdload_slot an=%b seg=%b expected an=%b seg=%b",
                             an, seg, exp.an, exp.seg);
                end
            end
        end
    endtask

    task automatic test_digit_enable;
        slot_t exp;
        logic  rdy;
        bit    ok;
        push_frame(16'h8888, 4'b0101, 4'h0);
        drive_load(16'h8888, 4'b0101, rdy);
        checks++;
        if (rdy !== 1'b1) begin
            failures++;
            $display("FAIL en_load_accept ready=%b expected 1", rdy);
        end
        wait_fd(ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL en_fd_timeout seen=0 expected 1");
        end
        @(negedge clk);
        while (sb.size() > 0) begin
            exp = sb.pop_front();
            for (int c = 0; c < SD; c++) begin
                @(negedge clk);
                checks++;
                if (an !== exp.an || seg !== exp.seg) begin
                    failures++;
                    $display("FAIL en_slot an=%b seg=%b expected an=%b seg=%b",
                             an, seg, exp.an, exp.seg);
                end
            end
        end
    endtask

`ifdef SSD_SCAN_DRIVER_BLINK_EN
    task automatic test_blink;
        slot_t exp;
        logic  rdy;
        bit    ok;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst        = 1'b0;
        blink_mask = 4'b0001;
        // Frame 1 visible, frames 2-3 digit 0 blank, frames 4-5 visible
        push_frame(16'h8888, 4'hF, 4'h0);
        push_frame(16'h8888, 4'hF, 4'b0001);
        push_frame(16'h8888, 4'hF, 4'b0001);
        push_frame(16'h8888, 4'hF, 4'h0);
        push_frame(16'h8888, 4'hF, 4'h0);
        drive_load(16'h8888, 4'hF, rdy);
        checks++;
        if (rdy !== 1'b1) begin
            failures++;
            $display("FAIL blink_load_accept ready=%b expected 1", rdy);
        end
        wait_fd(ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL blink_fd_timeout seen=0 expected 1");
        end
        @(negedge clk);
        while (sb.size() > 0) begin
            exp = sb.pop_front();
            for (int c = 0; c < SD; c++) begin
                @(negedge clk);
                checks++;
                if (an !== exp.an || seg !== exp.seg) begin
                    failures++;
                    $display("FAIL blink_slot an=%b seg=%b expected an=%b seg=%b",
                             an, seg, exp.an, exp.seg);
                end
            end
        end
        blink_mask = 4'b0000;
    endtask
`endif

    initial begin
`ifdef SSD_SCAN_DRIVER_BLINK_EN
        blink_mask = 4'b0000;
`endif
        test_reset();
        test_scan();
        test_back_to_back();
        test_load_on_frame_done();
        test_digit_enable();
`ifdef SSD_SCAN_DRIVER_BLINK_EN
        test_blink();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Hard stop if the sequence ever stalls
    initial begin
        #500000;
        $display("FAIL watchdog time=%0t expected completion before 500000", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
